// File: rtl/nfork_decoder.sv
// ============================================================================
//  Module      : nfork_decoder
//  Description : Receive-side decoder for the active-low wheel fork pulse.
//                Synchronises nfork, deglitches both edges and reports one
//                strobe, a wrapping revolution count and the revolution
//                period (in core_CLK cycles) per validated falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nfork_decoder #(
    parameter int PERIOD_W = 24,
    parameter int MIN_LOW  = 16,
    parameter int MIN_HIGH = 16,
    parameter int TIMEOUT  = 8_000_000
) (
    input  logic                core_CLK,
    input  logic                core_Reset,
    input  logic                nfork,
    output logic                rev_pulse,
    output logic [15:0]         rev_count,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stopped,
    output logic [7:0]          glitch_count
);

    localparam logic [7:0]          RUN_LOW_LAST  = 8'(MIN_LOW - 1);
    localparam logic [7:0]          RUN_HIGH_LAST = 8'(MIN_HIGH - 1);
    localparam logic [PERIOD_W-1:0] PCNT_LAST     = PERIOD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_HIGH    = 2'd0,
        ST_LOWCHK  = 2'd1,
        ST_LOW     = 2'd2,
        ST_HIGHCHK = 2'd3
    } state_t;

    logic                nfork_meta_q;
    logic                s_q;
    state_t              state_q;
    logic [7:0]          run_q;
    logic [7:0]          glitch_q;
    logic                val_d;
    logic                rev_pulse_q;
    logic [15:0]         rev_count_q;
    logic [PERIOD_W-1:0] period_q;
    logic                period_valid_q;
    logic                stopped_q;
    logic [PERIOD_W-1:0] pcnt_q;

    // Two-flop synchroniser, idles high so reset looks like "no pulse".
    always_ff @(posedge core_CLK) begin
        if (core_Reset) begin
            nfork_meta_q <= 1'b1;
            s_q          <= 1'b1;
        end else begin
            nfork_meta_q <= nfork;
            s_q          <= nfork_meta_q;
        end
    end

    // Falling edge is validated on the MIN_LOW-th consecutive low sample; the
    // outputs register it on that same edge to keep the latency fixed.
    always_comb begin
        val_d = 1'b0;
        case (state_q)
            ST_HIGH:   val_d = (MIN_LOW == 1) && !s_q;
            ST_LOWCHK: val_d = !s_q && (run_q == RUN_LOW_LAST);
            default:   val_d = 1'b0;
        endcase
    end

    // Deglitch FSM: a run must persist for its minimum length or it is
    // counted as a glitch and the previous level is resumed.
    always_ff @(posedge core_CLK) begin
        if (core_Reset) begin
            state_q  <= ST_HIGH;
            run_q    <= 8'd0;
            glitch_q <= 8'd0;
        end else begin
            case (state_q)
                ST_HIGH: begin
                    if (!s_q) begin
                        if (MIN_LOW == 1) begin
                            state_q <= ST_LOW;
                        end else begin
                            run_q   <= 8'd1;
                            state_q <= ST_LOWCHK;
                        end
                    end
                end
                ST_LOWCHK: begin
                    if (s_q) begin
                        if (glitch_q != 8'hFF) glitch_q <= glitch_q + 8'd1;
                        state_q <= ST_HIGH;
                    end else if (run_q == RUN_LOW_LAST) begin
                        state_q <= ST_LOW;
                    end else begin
                        run_q <= run_q + 8'd1;
                    end
                end
                ST_LOW: begin
                    if (s_q) begin
                        if (MIN_HIGH == 1) begin
                            state_q <= ST_HIGH;
                        end else begin
                            run_q   <= 8'd1;
                            state_q <= ST_HIGHCHK;
                        end
                    end
                end
                ST_HIGHCHK: begin
                    if (!s_q) begin
                        if (glitch_q != 8'hFF) glitch_q <= glitch_q + 8'd1;
                        state_q <= ST_LOW;
                    end else if (run_q == RUN_HIGH_LAST) begin
                        state_q <= ST_HIGH;
                    end else begin
                        run_q <= run_q + 8'd1;
                    end
                end
                default: state_q <= ST_HIGH;
            endcase
        end
    end

    // Revolution outputs and period counter; a validated edge beats timeout,
    // and the counter parks at TIMEOUT-1 instead of wrapping.
    always_ff @(posedge core_CLK) begin
        if (core_Reset) begin
            rev_pulse_q    <= 1'b0;
            rev_count_q    <= 16'd0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stopped_q      <= 1'b1;
            pcnt_q         <= '0;
        end else begin
            rev_pulse_q    <= val_d;
            period_valid_q <= 1'b0;
            if (val_d) begin
                rev_count_q <= rev_count_q + 16'd1;
                if (!stopped_q) begin
                    period_q       <= pcnt_q + 1'b1;
                    period_valid_q <= 1'b1;
                end else begin
                    stopped_q <= 1'b0;
                end
                pcnt_q <= '0;
            end else if (pcnt_q == PCNT_LAST) begin
                stopped_q <= 1'b1;
                period_q  <= '0;
            end else begin
                pcnt_q <= pcnt_q + 1'b1;
            end
        end
    end

    assign rev_pulse    = rev_pulse_q;
    assign rev_count    = rev_count_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stopped      = stopped_q;
    assign glitch_count = glitch_q;

endmodule

`default_nettype wire

// File: tb/tb_nfork_decoder.sv
// ============================================================================
//  Module      : tb_nfork_decoder
//  Description : Self-checking bench for nfork_decoder. Three instances with
//                different thresholds/timeouts share one nfork stimulus and
//                are compared every cycle against a run-length/timestamp model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nfork_decoder;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic nfork = 1'b1;

    always #5 clk = ~clk;

    logic [2:0]        rp, pv, st;
    logic [2:0][15:0]  rc;
    logic [2:0][23:0]  per;
    logic [2:0][7:0]   gc;

    nfork_decoder #(.PERIOD_W(24), .MIN_LOW(16), .MIN_HIGH(16), .TIMEOUT(8_000_000)) dut_a (
        .core_CLK(clk), .core_Reset(rst), .nfork(nfork), .rev_pulse(rp[0]), .rev_count(rc[0]),
        .period(per[0]), .period_valid(pv[0]), .stopped(st[0]), .glitch_count(gc[0]));
    nfork_decoder #(.PERIOD_W(24), .MIN_LOW(16), .MIN_HIGH(16), .TIMEOUT(1000)) dut_b (
        .core_CLK(clk), .core_Reset(rst), .nfork(nfork), .rev_pulse(rp[1]), .rev_count(rc[1]),
        .period(per[1]), .period_valid(pv[1]), .stopped(st[1]), .glitch_count(gc[1]));
    nfork_decoder #(.PERIOD_W(24), .MIN_LOW(1), .MIN_HIGH(1), .TIMEOUT(300)) dut_c (
        .core_CLK(clk), .core_Reset(rst), .nfork(nfork), .rev_pulse(rp[2]), .rev_count(rc[2]),
        .period(per[2]), .period_valid(pv[2]), .stopped(st[2]), .glitch_count(gc[2]));

    int ml[3]  = '{16, 16, 1};
    int mh[3]  = '{16, 16, 1};
    int mto[3] = '{8_000_000, 1000, 300};

    // Model state: filtered level, run lengths of equal samples, timestamp of
    // the last period reference point.
    bit          m_s1, m_s, m_started;
    bit          m_flt[3], m_prev[3];
    int          m_lo[3], m_hi[3], m_gl[3];
    longint      m_last[3];
    longint      cyc;
    bit          m_rp[3], m_pv[3], m_st[3];
    logic [15:0] m_cnt[3];
    logic [23:0] m_per[3];

    bit          preload_req, cmp_hold;
    int          checks, errors;
    int          pvn[3], rpn[3];
    logic [23:0] lastper[3];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input int len);
        nfork = 1'b0;
        repeat (len) tick();
        nfork = 1'b1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    int snap_pv, snap_rp;

    initial begin
        fork
            // Reference model, evaluated on the input values seen at each edge.
            forever begin
                @(posedge clk);
                cyc++;
                if (rst) begin
                    for (int i = 0; i < 3; i++) begin
                        m_flt[i] = 1; m_prev[i] = 1; m_lo[i] = 0; m_hi[i] = 0;
                        m_last[i] = cyc; m_rp[i] = 0; m_pv[i] = 0; m_st[i] = 1;
                        m_cnt[i] = 0; m_per[i] = 0; m_gl[i] = 0;
                    end
                    m_s1 = 1; m_s = 1;
                end else begin
                    if (preload_req) m_cnt[0] = 16'hFFFF;
                    for (int i = 0; i < 3; i++) begin
                        bit v, g;
                        longint age;
                        v = 0; g = 0;
                        if (!m_s) begin
                            m_lo[i] = m_prev[i] ? 1 : m_lo[i] + 1;
                            m_hi[i] = 0;
                        end else begin
                            m_hi[i] = m_prev[i] ? m_hi[i] + 1 : 1;
                            m_lo[i] = 0;
                        end
                        if (m_flt[i]) begin
                            if (!m_s && m_lo[i] == ml[i]) begin v = 1; m_flt[i] = 0; end
                            else if (m_s && !m_prev[i]) g = 1;
                        end else begin
                            if (m_s && m_hi[i] == mh[i]) m_flt[i] = 1;
                            else if (!m_s && m_prev[i]) g = 1;
                        end
                        m_prev[i] = m_s;
                        m_rp[i] = v;
                        m_pv[i] = 0;
                        age = cyc - m_last[i];
                        if (v) begin
                            m_cnt[i] = m_cnt[i] + 16'd1;
                            if (!m_st[i]) begin m_per[i] = 24'(age); m_pv[i] = 1; end
                            else m_st[i] = 0;
                            m_last[i] = cyc;
                        end else if (age >= mto[i]) begin
                            m_st[i] = 1;
                            m_per[i] = 0;
                        end
                        if (g && m_gl[i] < 255) m_gl[i]++;
                    end
                    m_s = m_s1;
                    m_s1 = nfork;
                end
                m_started = 1;
            end
            // Cycle-by-cycle comparison on the falling clock edge.
            forever begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    if (pv[i]) begin pvn[i]++; lastper[i] = per[i]; end
                    if (rp[i]) rpn[i]++;
                    if (m_started && !cmp_hold) begin
                        chk($sformatf("dut%0d.rev_pulse", i),    rp[i],  m_rp[i]);
                        chk($sformatf("dut%0d.rev_count", i),    rc[i],  m_cnt[i]);
                        chk($sformatf("dut%0d.period", i),       per[i], m_per[i]);
                        chk($sformatf("dut%0d.period_valid", i), pv[i],  m_pv[i]);
                        chk($sformatf("dut%0d.stopped", i),      st[i],  m_st[i]);
                        chk($sformatf("dut%0d.glitch_count", i), gc[i],  m_gl[i]);
                    end
                end
            end
        join_none

        // Reset defaults
        rst = 1'b1;
        repeat (3) tick();
        chk("reset.rev_pulse", rp[0], 0);
        chk("reset.rev_count", rc[0], 0);
        chk("reset.period", per[0], 0);
        chk("reset.period_valid", pv[0], 0);
        chk("reset.stopped", st[0], 1);
        chk("reset.glitch_count", gc[0], 0);
        rst = 1'b0;
        idle(20);

        // First pulse: strobe exactly after edge k+17, no period yet
        nfork = 1'b0;
        repeat (17) tick();
        chk("first.early_rev_pulse", rp[0], 0);
        tick();
        chk("first.rev_pulse", rp[0], 1);
        chk("first.rev_count", rc[0], 1);
        chk("first.period_valid", pv[0], 0);
        chk("first.stopped", st[0], 0);
        repeat (47) tick();
        nfork = 1'b1;
        idle(200);

        // Steady period of 3277 cycles, five pulses
        do_reset(3);
        idle(20);
        snap_pv = pvn[0];
        repeat (5) begin
            pulse(65);
            idle(3277 - 65);
        end
        chk("steady.pv_strobes", pvn[0] - snap_pv, 4);
        chk("steady.period", lastper[0], 3277);
        chk("steady.rev_count", rc[0], 5);
        chk("steady.glitch_count", gc[0], 0);

        // Glitch rejection thresholds
        do_reset(3);
        idle(20);
        pulse(15); idle(40);
        chk("glitch15.glitch_count", gc[0], 1);
        chk("glitch15.rev_count", rc[0], 0);
        pulse(16); idle(40);
        chk("low16.rev_count", rc[0], 1);
        pulse(30); idle(10); pulse(25); idle(40);
        chk("gap.rev_count", rc[0], 2);
        chk("gap.glitch_count", gc[0], 2);

        // Timeout on the TIMEOUT=1000 instance
        do_reset(3);
        idle(20);
        pulse(65); idle(435);
        nfork = 1'b0;
        repeat (18) tick();
        chk("timeout.period_500", per[1], 500);
        repeat (47) tick();
        nfork = 1'b1;
        repeat (952) tick();
        chk("timeout.not_yet_stopped", st[1], 0);
        tick();
        chk("timeout.stopped", st[1], 1);
        chk("timeout.period_zero", per[1], 0);
        idle(183);
        snap_pv = pvn[1];
        snap_rp = rpn[1];
        pulse(65); idle(435);
        chk("timeout.restart_pulses", rpn[1] - snap_rp, 1);
        chk("timeout.restart_no_pv", pvn[1] - snap_pv, 0);
        pulse(65); idle(100);
        chk("timeout.next_pv", pvn[1] - snap_pv, 1);
        chk("timeout.next_period", lastper[1], 500);

        // rev_count wrap via preload
        do_reset(3);
        idle(20);
        cmp_hold = 1'b1;
        preload_req = 1'b1;
        force dut_a.rev_count_q = 16'hFFFF;
        tick();
        release dut_a.rev_count_q;
        preload_req = 1'b0;
        cmp_hold = 1'b0;
        pulse(65); idle(40);
        chk("wrap.rev_count", rc[0], 0);

        // glitch_count saturation
        repeat (300) begin
            pulse(5); idle(20);
        end
        chk("sat.glitch_count", gc[0], 255);

        // Reset in the middle of a pulse
        idle(40);
        snap_rp = rpn[0];
        nfork = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        nfork = 1'b1;
        repeat (2) tick();
        chk("midrst.rev_count", rc[0], 0);
        chk("midrst.glitch_count", gc[0], 0);
        chk("midrst.stopped", st[0], 1);
        chk("midrst.period", per[0], 0);
        rst = 1'b0;
        idle(60);
        chk("midrst.no_rev_pulse", rpn[0] - snap_rp, 0);
        chk("midrst.rev_count_after", rc[0], 0);

        // Low held through reset release still validates
        snap_pv = pvn[0];
        rst = 1'b1;
        nfork = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (62) tick();
        nfork = 1'b1;
        idle(40);
        chk("lowrst.rev_count", rc[0], 1);
        chk("lowrst.no_pv", pvn[0] - snap_pv, 0);

        // Randomised segments, checked by the per-cycle comparison
        repeat (300) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset($urandom_range(1, 3));
            end else if (r < 6) begin
                idle($urandom_range(200, 1200));
            end else begin
                pulse($urandom_range(1, 40));
                idle($urandom_range(1, 60));
            end
        end
        idle(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
